// File: rtl/vram_frame_sequencer.sv
// Frame sequencer for a bank of 128x128x1 frame BRAMs: maps VGA counters into a fixed
// window, enables only the current frame's BRAM and steps frames on vertical blanking.
module vram_frame_sequencer #(
    parameter int NUM_FRAMES = 12,
    parameter int X0         = 256,
    parameter int Y0         = 176,
    localparam int IDX_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            h_count,
    input  logic [9:0]            v_count,
    input  logic                  video_on,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [7:0]            hold_frames,
    output logic [13:0]           vram_addr,
    output logic [NUM_FRAMES-1:0] vram_en,
    input  logic [NUM_FRAMES-1:0] vram_pixel,
    output logic                  pixel_out,
    output logic                  pixel_valid,
    output logic [IDX_W-1:0]      frame_idx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [10:0]      X_LO     = 11'(X0);
    localparam logic [10:0]      X_HI     = 11'(X0 + 128);
    localparam logic [10:0]      Y_LO     = 11'(Y0);
    localparam logic [10:0]      Y_HI     = 11'(Y0 + 128);
    localparam logic [6:0]       X0_LOW   = 7'(X0);
    localparam logic [6:0]       Y0_LOW   = 7'(Y0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_frame_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [7:0]            r_tick_cnt;
    logic [7:0]            w_tick_nxt;
    logic                  r_done;
    logic                  w_done_nxt;

    logic [13:0]           r_addr;
    logic [NUM_FRAMES-1:0] r_en;
    logic                  r_win1;
    logic                  r_win2;
    logic [IDX_W-1:0]      r_idx1;
    logic [IDX_W-1:0]      r_idx2;
    logic                  r_pix;
    logic                  r_pix_valid;

    logic                  w_in_win;
    logic [6:0]            w_x_off;
    logic [6:0]            w_y_off;
    logic [NUM_FRAMES-1:0] w_onehot;
    logic                  w_sel_pix;
    logic [7:0]            w_hold;
    logic                  w_step;

    assign w_in_win = video_on
                    && ({1'b0, h_count} >= X_LO) && ({1'b0, h_count} < X_HI)
                    && ({1'b0, v_count} >= Y_LO) && ({1'b0, v_count} < Y_HI);

    // Only the low 7 bits of the offset are needed inside the window.
    assign w_x_off   = h_count[6:0] - X0_LOW;
    assign w_y_off   = v_count[6:0] - Y0_LOW;
    assign w_onehot  = NUM_FRAMES'(1) << r_frame_idx;
    assign w_sel_pix = vram_pixel[r_idx2];

    // Stages 1..3: address/enable, BRAM read, pixel mux on the index that travelled with the address.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
        if (reset) begin
            r_addr      <= '0;
            r_en        <= '0;
            r_win1      <= 1'b0;
            r_win2      <= 1'b0;
            r_idx1      <= '0;
            r_idx2      <= '0;
            r_pix       <= 1'b0;
            r_pix_valid <= 1'b0;
        end else begin
            if (w_in_win)
                r_addr <= {w_y_off, w_x_off};
            r_en        <= w_in_win ? w_onehot : '0;
            r_win1      <= w_in_win;
            r_idx1      <= r_frame_idx;
            r_win2      <= r_win1;
            r_idx2      <= r_idx1;
            r_pix       <= r_win2 ? w_sel_pix : 1'b0;
            r_pix_valid <= r_win2;
        end
    end

    assign w_hold = (hold_frames == 8'd0) ? 8'd1 : hold_frames;
    assign w_step = ({1'b0, r_tick_cnt} + 9'd1) >= {1'b0, w_hold};

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_idx_nxt   = r_frame_idx;
        w_tick_nxt  = r_tick_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_PLAY;
                    w_idx_nxt   = '0;
                    w_tick_nxt  = '0;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (frame_tick) begin
                    if (!w_step) begin
                        w_tick_nxt = r_tick_cnt + 8'd1;
                    end else begin
                        w_tick_nxt = '0;
                        if (r_frame_idx < LAST_IDX) begin
                            w_idx_nxt = r_frame_idx + 1'b1;
                        end else if (loop_en) begin
                            w_idx_nxt = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_frame_idx <= '0;
            r_tick_cnt  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_idx <= w_idx_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign vram_addr   = r_addr;
    assign vram_en     = r_en;
    assign pixel_out   = r_pix;
    assign pixel_valid = r_pix_valid;
    assign frame_idx   = r_frame_idx;
    assign busy        = (r_state == S_PLAY);
    assign done        = r_done;

endmodule

// File: tb/tb_vram_frame_sequencer.sv
// Directed bench for vram_frame_sequencer: window scan against a behavioural BRAM bank,
// exact pipeline latency, frame mux and the play/stop/loop sequencing.
module tb_vram_frame_sequencer;

    localparam int NF = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    h_count;
    logic [9:0]    v_count;
    logic          video_on;
    logic          frame_tick;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [7:0]    hold_frames;
    logic [13:0]   vram_addr;
    logic [NF-1:0] vram_en;
    logic [NF-1:0] vram_pixel;
    logic          pixel_out;
    logic          pixel_valid;
    logic [3:0]    frame_idx;
    logic          busy;
    logic          done;

    vram_frame_sequencer #(.NUM_FRAMES(NF), .X0(256), .Y0(176)) dut (
        .clk         (clk),
        .reset       (reset),
        .h_count     (h_count),
        .v_count     (v_count),
        .video_on    (video_on),
        .frame_tick  (frame_tick),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .hold_frames (hold_frames),
        .vram_addr   (vram_addr),
        .vram_en     (vram_en),
        .vram_pixel  (vram_pixel),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .frame_idx   (frame_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM bank: one-cycle read, frame 0 holds a checker-like pattern.
    logic [NF-1:0] bram_q    = '0;
    logic          use_const = 1'b0;
    logic [NF-1:0] const_pix = '0;

    always @(posedge clk) begin
        for (int i = 0; i < NF; i++)
            if (vram_en[i])
                bram_q[i] <= (i == 0) ? (vram_addr[0] ^ vram_addr[7] ^ vram_addr[13]) : 1'b0;
    end

    assign vram_pixel = use_const ? const_pix : bram_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic valid;
        logic pix;
    } exp_t;

    exp_t        q[$];
    logic [13:0] last_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call only when the two previous stage inputs were outside the window or the pipe was reset.
    task automatic resync();
        exp_t z;
        z = '0;
        q.delete();
        q.push_back(z);
        q.push_back(z);
    endtask

    task automatic apply(input int h, input int v, input logic von, input int fidx);
        int   x;
        int   y;
        logic win;
        exp_t e;
        h_count  = 10'(h);
        v_count  = 10'(v);
        video_on = von;
        x        = h - 256;
        y        = v - 176;
        win      = von && (x >= 0) && (x < 128) && (y >= 0) && (y < 128);
        e.valid  = win;
        if (!win)          e.pix = 1'b0;
        else if (use_const) e.pix = const_pix[fidx];
        else               e.pix = (fidx == 0) ? (x[0] ^ y[0] ^ y[6]) : 1'b0;
        q.push_back(e);
        tick();
        check("en", 32'(vram_en), win ? (32'd1 << fidx) : 32'd0);
        if (win) last_addr = {y[6:0], x[6:0]};
        check("addr", 32'(vram_addr), 32'(last_addr));
        if (q.size() >= 3) begin
            e = q.pop_front();
            check("valid", 32'(pixel_valid), 32'(e.valid));
            check("pix", 32'(pixel_out), 32'(e.pix));
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        frame_tick = 1'b0;
        video_on   = 1'b0;
        tick();
        reset      = 1'b0;
        last_addr  = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    initial begin
        int lines[6] = '{175, 176, 177, 240, 303, 304};
        int exp_idx;
        h_count = '0; v_count = '0; loop_en = 1'b0; hold_frames = 8'd1;
        do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_addr", 32'(vram_addr), 32'd0);
        check("rst_en", 32'(vram_en), 32'd0);
        check("rst_pix", 32'(pixel_out), 32'd0);
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_idx", 32'(frame_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Window scan on frame 0, including lines and columns just outside the window.
        resync();
        for (int l = 0; l < 6; l++)
            for (int h = 250; h <= 390; h++)
                apply(h, lines[l], 1'b1, 0);
        apply(300, 200, 1'b0, 0);
        apply(300, 200, 1'b0, 0);
        apply(300, 200, 1'b0, 0);

        // One-shot playback, two display frames per step.
        do_reset();
        hold_frames = 8'd2;
        loop_en     = 1'b0;
        do_start();
        check("play_busy", 32'(busy), 32'd1);
        check("play_idx0", 32'(frame_idx), 32'd0);
        for (int t = 1; t <= 24; t++) begin
            pulse_tick();
            exp_idx = (t >= 22) ? 11 : t / 2;
            check("play_idx", 32'(frame_idx), 32'(exp_idx));
            check("play_done", 32'(done), (t == 24) ? 32'd1 : 32'd0);
            check("play_busy", 32'(busy), (t == 24) ? 32'd0 : 32'd1);
            tick();
        end
        check("end_done", 32'(done), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_idx", 32'(frame_idx), 32'd11);
        pulse_tick();
        check("idle_idx", 32'(frame_idx), 32'd11);

        // Looping playback with hold_frames=0 (one step per tick).
        do_reset();
        hold_frames = 8'd0;
        loop_en     = 1'b1;
        do_start();
        for (int t = 1; t <= 14; t++) begin
            pulse_tick();
            check("loop_idx", 32'(frame_idx), 32'(t % 12));
            check("loop_done", 32'(done), 32'd0);
            check("loop_busy", 32'(busy), 32'd1);
        end

        // Frame mux and exact latency: only frame 11 carries a lit pixel.
        for (int t = 0; t < 9; t++) pulse_tick();
        check("mux_idx11", 32'(frame_idx), 32'd11);
        use_const = 1'b1;
        const_pix = 12'h800;
        resync();
        apply(300, 200, 1'b1, 11);
        apply(300, 200, 1'b0, 11);
        apply(300, 200, 1'b0, 11);
        apply(300, 200, 1'b0, 11);
        for (int t = 0; t < 11; t++) pulse_tick();
        check("mux_idx10", 32'(frame_idx), 32'd10);
        resync();
        apply(301, 201, 1'b1, 10);
        apply(301, 201, 1'b0, 10);
        apply(301, 201, 1'b0, 10);
        use_const = 1'b0;

        // stop wins over a due frame_tick.
        do_reset();
        hold_frames = 8'd1;
        loop_en     = 1'b0;
        do_start();
        for (int t = 0; t < 5; t++) pulse_tick();
        check("stop_pre_idx", 32'(frame_idx), 32'd5);
        stop       = 1'b1;
        frame_tick = 1'b1;
        tick();
        stop       = 1'b0;
        frame_tick = 1'b0;
        check("stop_idx", 32'(frame_idx), 32'd5);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        tick();
        check("stop_done2", 32'(done), 32'd0);
        do_start();
        check("restart_idx", 32'(frame_idx), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);

        // Reset mid-line inside the window while playing frame 3.
        for (int t = 0; t < 3; t++) pulse_tick();
        use_const = 1'b1;
        const_pix = 12'h008;
        resync();
        for (int t = 0; t < 4; t++) apply(320 + t, 250, 1'b1, 3);
        reset = 1'b1;
        tick();
        check("mrst_addr", 32'(vram_addr), 32'd0);
        check("mrst_en", 32'(vram_en), 32'd0);
        check("mrst_pix", 32'(pixel_out), 32'd0);
        check("mrst_valid", 32'(pixel_valid), 32'd0);
        check("mrst_idx", 32'(frame_idx), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        reset     = 1'b0;
        last_addr = '0;
        resync();
        for (int t = 0; t < 4; t++) apply(330 + t, 250, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_frame_sequencer.md
# vram_frame_sequencer

Animation controller for the 128x128x1 monochrome frame BRAMs in the VGA VRAM. It turns the VGA timing counters into a 14-bit BRAM read address inside a fixed on-screen window. It enables only the BRAM holding the current frame and muxes that BRAM's pixel back out with matching latency. It also steps through frames at vertical-frame boundaries, with a play, stop and loop FSM. It sits between the VGA timing generator and the bank of frame BRAMs and drives the colour stage.

## Interface
- NUM_FRAMES, 12, number of frame BRAMs (2..16); IDX_W = 4 (localparam)
- X0, 256, left column of the 128-pixel-wide window
- Y0, 176, top line of the 128-line window
- clk  in  1  pixel clock; h_count advances once per cycle
- reset  in  1  synchronous, active-high; also drives the BRAM reset pins
- h_count  in  10  current column
- v_count  in  10  current line
- video_on  in  1  active display region
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- start  in  1  level-sampled; begin playback from frame 0
- stop  in  1  level-sampled; freeze on current frame
- loop_en  in  1  wrap to frame 0 after last frame
- hold_frames  in  8  display frames per animation step (0 treated as 1)
- vram_addr  out  14  BRAM read address {y_off[6:0], x_off[6:0]}
- vram_en  out  NUM_FRAMES  one-hot BRAM read enables
- vram_pixel  in  NUM_FRAMES  pixel_val from each BRAM, bit i = frame i
- pixel_out  out  1  pixel, 0 outside window
- pixel_valid  out  1  pixel_out lies inside window
- frame_idx  out  IDX_W  frame currently displayed
- busy  out  1  state == PLAY
- done  out  1  one-cycle pulse on one-shot completion

## Operation
- Window: in_win = video_on & X0 <= h_count < X0+128 & Y0 <= v_count < Y0+128.
  - Offsets: x_off = h_count-X0 and y_off = v_count-Y0, 7 bits each, truncated.
- Stage 1 (registered):
  - vram_addr <= in_win ? {y_off, x_off} : vram_addr (holds last value).
  - vram_en <= in_win ? onehot(frame_idx) : 0.
  - win1 <= in_win; idx1 <= frame_idx.
- Stage 2: win2 <= win1; idx2 <= idx1. The BRAM output is valid in this cycle because DOA_REG=0.
- Stage 3: pixel_out <= win2 ? vram_pixel[idx2] : 0; pixel_valid <= win2.
- The mux uses the pipelined idx2, never the live frame_idx.
- FSM states: IDLE, PLAY. tick_cnt is 8 bits.
  - IDLE: start=1 -> PLAY; frame_idx <= 0, tick_cnt <= 0. frame_idx is otherwise held.
  - PLAY, stop=1 -> IDLE. frame_idx is held, done is not asserted. stop has priority over frame_tick and start in the same cycle.
  - PLAY, frame_tick, tick_cnt+1 < max(hold_frames,1) -> tick_cnt++.
  - PLAY, frame_tick, step reached -> tick_cnt <= 0, then:
    - frame_idx < NUM_FRAMES-1 -> frame_idx++.
    - Last frame with loop_en=1 -> frame_idx <= 0.
    - Last frame with loop_en=0 -> IDLE, frame_idx stays at NUM_FRAMES-1, done=1 for one cycle.
  - start while in PLAY is ignored.
- hold_frames and loop_en are sampled live at each frame_tick.
- frame_idx never exceeds NUM_FRAMES-1.

## Timing
- Reset values:
  - vram_addr=0, vram_en=0, pixel_out=0, pixel_valid=0.
  - frame_idx=0, busy=0, done=0.
  - state=IDLE, tick_cnt=0, win1=win2=0, idx1=idx2=0.
- Latency: h_count/v_count presented in cycle c -> pixel_out and pixel_valid in cycle c+3.
- vram_en rises in cycle c+1 for input in cycle c. At most one bit of vram_en is set.
- frame_idx changes only in the cycle after frame_tick (or after start/stop), so no frame change occurs mid-line inside the window.
- Reset asserted mid-line: all outputs are forced to reset values on the next edge. The pipeline refills, and pixel_valid returns 3 cycles after in_win.
- Window edges:
  - h_count=X0+127 is inside the window; X0+128 is outside.
  - Line Y0+127 is the last line, with vram_addr=16383 at its last pixel.

## Test plan
- Reset, then scan the full frame with frame_idx=0 and vram_pixel=bit0 pattern:
  - h=256, v=176 -> vram_addr=0 and vram_en=0x001 at c+1; pixel_valid=1 at c+3.
  - h=383, v=303 -> addr=16383.
  - h=384 -> pixel_valid=0 and pixel_out=0.
- Latency and mux: vram_pixel=12'h800, frame_idx=11 -> pixel_out=1 exactly 3 cycles after the in-window input; 0 when frame_idx=10.
- Playback, hold_frames=2, loop_en=0, start:
  - frame_idx steps 0,1,…,11 on every 2nd frame_tick.
  - After the 24th tick: state IDLE, frame_idx=11, one-cycle done, busy=0.
- loop_en=1, hold_frames=0 -> advance on every tick; 11 -> 0 wrap; done is never asserted.
- stop and frame_tick in the same cycle during PLAY (frame_idx=5, step due) -> IDLE, frame_idx stays 5, no done. A later start -> frame_idx=0.
- Reset asserted during PLAY in the middle of the window -> next cycle all outputs 0, frame_idx=0, state IDLE.
